// File: rtl/msb_normalizer.sv
// Streaming unsigned normalizer: MSB index as exponent, bits below it left-aligned as mantissa.
// Define MSB_NORMALIZER_ROUND_EN for round-half-to-even of discarded bits; truncation otherwise.
module msb_normalizer #(
  parameter int IN_WIDTH   = 32,
  parameter int MANT_WIDTH = 23,
  localparam int EXP_WIDTH = $clog2(IN_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_zero,
  output logic [EXP_WIDTH-1:0]  out_exp,
  output logic [MANT_WIDTH-1:0] out_mant
);

  localparam int PW = $clog2(IN_WIDTH);

  logic                  s1_valid;
  logic [IN_WIDTH-1:0]   s1_data;
  logic                  s1_zero;
  logic [PW-1:0]         s1_p;
  logic                  s2_valid;
  logic                  s2_load;
  logic                  s1_load;
  logic [PW-1:0]         p_enc;
  logic [MANT_WIDTH-1:0] mant_next;
  logic [EXP_WIDTH-1:0]  exp_next;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  always_comb begin
    p_enc = '0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      if (in_data[i]) p_enc = PW'(i);
    end
  end

`ifdef MSB_NORMALIZER_ROUND_EN
  // Low IN_WIDTH bits of frac hold the discarded bits: top one is guard, rest feed sticky.
  logic [MANT_WIDTH+IN_WIDTH-1:0] frac;
  logic                           guard;
  logic                           sticky;
  logic                           inc;
  logic [MANT_WIDTH:0]            sum;

  always_comb begin
    frac      = (MANT_WIDTH + IN_WIDTH)'({s1_data, {(MANT_WIDTH + IN_WIDTH){1'b0}}} >> s1_p);
    guard     = frac[IN_WIDTH-1];
    sticky    = |frac[IN_WIDTH-2:0];
    inc       = guard && (sticky || frac[IN_WIDTH]);
    sum       = {1'b0, frac[MANT_WIDTH+IN_WIDTH-1:IN_WIDTH]} + (MANT_WIDTH + 1)'(inc);
    mant_next = sum[MANT_WIDTH-1:0];
    exp_next  = EXP_WIDTH'(s1_p) + EXP_WIDTH'(sum[MANT_WIDTH]);
  end
`else
  // Shifting right by p places the MSB just above the mantissa field, so truncation drops it.
  always_comb begin
    mant_next = MANT_WIDTH'({s1_data, {MANT_WIDTH{1'b0}}} >> s1_p);
    exp_next  = EXP_WIDTH'(s1_p);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_zero  <= 1'b0;
      s1_p     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_zero <= ~|in_data;
        s1_p    <= p_enc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_zero <= 1'b0;
      out_exp  <= '0;
      out_mant <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_zero <= s1_zero;
        out_exp  <= exp_next;
        out_mant <= mant_next;
      end
    end
  end

endmodule
